div_seq_param: RTL and testbench

Parametrised multi-cycle integer divider. It computes one quotient bit per clock using restoring division, and supports signed and unsigned operation selected per operation. It has valid/ready handshakes on both input and output, so it can sit behind a CPU execute stage or any streaming datapath. It is the sequential, width-generic successor to the team's combinational 32-bit dividers.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 25 ++
 rtl/div_seq_param.sv | 145 ++++++++++++++
 tb/tb_div_seq_param.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the iteration-counter width helper.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned W_MIN = 4;
  localparam int unsigned W_MAX = 64;

  // Counter must hold the value W itself, hence W+1 codes.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor magnitude, keep or restore.
module div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // rem_i < dvs_i always holds, so shifted < 2*dvs_i and diff[W] is exactly
  // the borrow of the W+1-bit trial subtraction.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, dvs_i};
    q_o     = ~diff[W];
    rem_o   = q_o ? diff[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/div_seq_param.sv
// Parametrised multi-cycle signed/unsigned integer divider with valid/ready
// handshakes; one quotient bit per clock.
module div_seq_param
  import div_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = cnt_width(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_signed,
  input  logic [W-1:0] dived,
  input  logic [W-1:0] divor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quoti,
  output logic [W-1:0] remai,
  output logic         div_zero
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       rem_q, rem_d;
  logic [W-1:0]       dvd_q, dvd_d;
  logic [W-1:0]       dvs_q, dvs_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [W-1:0]       quoti_q, quoti_d;
  logic [W-1:0]       remai_q, remai_d;
  logic               dz_q, dz_d;

  logic               neg_a, neg_b, ovf;
  logic [W-1:0]       mag_a, mag_b;
  logic [W-1:0]       int_min;
  logic [W-1:0]       step_rem;
  logic               step_q;
  logic [W-1:0]       quo_shift;

  div_step #(.W(W)) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[W-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    int_min   = {1'b1, {(W-1){1'b0}}};
    neg_a     = in_signed & dived[W-1];
    neg_b     = in_signed & divor[W-1];
    mag_a     = neg_a ? (~dived + W'(1)) : dived;
    mag_b     = neg_b ? (~divor + W'(1)) : divor;
    ovf       = in_signed && (dived == int_min) && (divor == '1);
    quo_shift = {dvd_q[W-2:0], step_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quoti_d   = quoti_q;
    remai_d   = remai_q;
    dz_d      = dz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          neg_quo_d = neg_a ^ neg_b;
          neg_rem_d = neg_a;
          if (divor == '0) begin
            quoti_d = '1;
            remai_d = dived;
            dz_d    = 1'b1;
            state_d = DONE;
          end else if (ovf) begin
            quoti_d = dived;
            remai_d = '0;
            dz_d    = 1'b0;
            state_d = DONE;
          end else begin
            rem_d   = '0;
            dvd_d   = mag_a;
            dvs_d   = mag_b;
            cnt_d   = CNT_W'(W);
            dz_d    = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // The dividend register doubles as the quotient shift register.
        rem_d = step_rem;
        dvd_d = quo_shift;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          quoti_d = neg_quo_q ? (~quo_shift + W'(1)) : quo_shift;
          remai_d = neg_rem_q ? (~step_rem + W'(1)) : step_rem;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quoti_q   <= '0;
      remai_q   <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quoti_q   <= quoti_d;
      remai_q   <= remai_d;
      dz_q      <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quoti     = quoti_q;
  assign remai     = remai_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_div_seq_param.sv
// Scoreboard bench for div_seq_param at W=32 and W=8: a driver queues the
// expected results, per-DUT monitors pop and compare on each output handshake.
module tb_div_seq_param;

  localparam int unsigned WA = 32;
  localparam int unsigned WB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic          a_in_valid = 1'b0, a_in_signed = 1'b0, a_out_ready = 1'b1;
  logic          a_in_ready, a_out_valid, a_div_zero;
  logic [WA-1:0] a_dived = '0, a_divor = '0;
  logic [WA-1:0] a_quoti, a_remai;

  logic          b_in_valid = 1'b0, b_in_signed = 1'b0, b_out_ready = 1'b1;
  logic          b_in_ready, b_out_valid, b_div_zero;
  logic [WB-1:0] b_dived = '0, b_divor = '0;
  logic [WB-1:0] b_quoti, b_remai;

  div_seq_param #(.W(WA)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_signed(a_in_signed), .dived(a_dived), .divor(a_divor),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .quoti(a_quoti),
    .remai(a_remai), .div_zero(a_div_zero)
  );

  div_seq_param #(.W(WB)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_signed(b_in_signed), .dived(b_dived), .divor(b_divor),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .quoti(b_quoti),
    .remai(b_remai), .div_zero(b_div_zero)
  );

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        z;
    int          lat;
    int          acc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Latency = rising edges from the accepting edge to the edge that raises
  // out_valid; the special cases register their result on the accepting edge.
  int            a_first = 0;
  logic          a_vprev = 1'b0;
  logic [WA-1:0] a_qs, a_rs;
  logic          a_zs;
  exp_t          a_e;
  always begin
    @(negedge clk); #1;
    if (rst) a_vprev = 1'b0;
    else begin
      if (a_out_valid) begin
        if (!a_vprev) a_first = cyc;
        else begin
          chk("A hold quoti", a_quoti, a_qs);
          chk("A hold remai", a_remai, a_rs);
          chk("A hold div_zero", a_div_zero, a_zs);
        end
        a_qs = a_quoti; a_rs = a_remai; a_zs = a_div_zero;
        if (a_out_ready) begin
          if (qa.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL A unexpected result: got quoti 0x%0h with no pending op", a_quoti);
          end else begin
            a_e = qa.pop_front();
            chk("A quoti", a_quoti, a_e.q);
            chk("A remai", a_remai, a_e.r);
            chk("A div_zero", a_div_zero, a_e.z);
            chk("A latency", a_first - a_e.acc, a_e.lat);
          end
        end
      end
      a_vprev = a_out_valid && !a_out_ready;
    end
  end

  int            b_first = 0;
  logic          b_vprev = 1'b0;
  logic [WB-1:0] b_qs, b_rs;
  logic          b_zs;
  exp_t          b_e;
  always begin
    @(negedge clk); #1;
    if (rst) b_vprev = 1'b0;
    else begin
      if (b_out_valid) begin
        if (!b_vprev) b_first = cyc;
        else begin
          chk("B hold quoti", b_quoti, b_qs);
          chk("B hold remai", b_remai, b_rs);
          chk("B hold div_zero", b_div_zero, b_zs);
        end
        b_qs = b_quoti; b_rs = b_remai; b_zs = b_div_zero;
        if (b_out_ready) begin
          if (qb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL B unexpected result: got quoti 0x%0h with no pending op", b_quoti);
          end else begin
            b_e = qb.pop_front();
            chk("B quoti", b_quoti, b_e.q);
            chk("B remai", b_remai, b_e.r);
            chk("B div_zero", b_div_zero, b_e.z);
            chk("B latency", b_first - b_e.acc, b_e.lat);
          end
        end
      end
      b_vprev = b_out_valid && !b_out_ready;
    end
  end

  task automatic issue(input bit sel, input bit sg, input logic [63:0] a, input logic [63:0] b,
                       input bit track, input logic [63:0] eq, input logic [63:0] er,
                       input bit ez, input int elat);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!(sel ? b_in_ready : a_in_ready) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL issue timeout: in_ready got 0 expected 1 (dut %0d)", sel);
      return;
    end
    if (sel) begin
      b_in_signed = sg; b_dived = a[WB-1:0]; b_divor = b[WB-1:0]; b_in_valid = 1'b1;
    end else begin
      a_in_signed = sg; a_dived = a[WA-1:0]; a_divor = b[WA-1:0]; a_in_valid = 1'b1;
    end
    @(posedge clk); #1;
    if (track) begin
      e.q = eq; e.r = er; e.z = ez; e.lat = elat; e.acc = cyc;
      if (sel) qb.push_back(e); else qa.push_back(e);
    end
    @(negedge clk);
    // Scramble the pins after accept; the DUT must have latched its operands.
    if (sel) begin
      b_in_valid = 1'b0; b_dived = ~b_dived; b_divor = b_divor ^ 8'h5a; b_in_signed = ~b_in_signed;
    end else begin
      a_in_valid = 1'b0; a_dived = ~a_dived; a_divor = a_divor ^ 32'h5a5a5a5a; a_in_signed = ~a_in_signed;
    end
  endtask

  task automatic drain(input bit sel);
    int guard;
    guard = 0;
    while (((sel ? qb.size() : qa.size()) != 0 || !(sel ? b_in_ready : a_in_ready)) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL drain timeout: pending got %0d expected 0 (dut %0d)", sel ? qb.size() : qa.size(), sel);
    end
  endtask

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    chk("A reset in_ready", a_in_ready, 1);
    chk("A reset out_valid", a_out_valid, 0);
    chk("A reset quoti", a_quoti, 0);
    chk("A reset remai", a_remai, 0);
    chk("A reset div_zero", a_div_zero, 0);
    chk("B reset in_ready", b_in_ready, 1);
    chk("B reset out_valid", b_out_valid, 0);
    rst = 1'b0;

    issue(0, 0, 100, 7, 1, 14, 2, 0, 32);
    issue(0, 1, 64'hFFFFFFF9, 2, 1, 64'hFFFFFFFD, 64'hFFFFFFFF, 0, 32);
    issue(0, 1, 7, 64'hFFFFFFFE, 1, 64'hFFFFFFFD, 1, 0, 32);
    issue(0, 1, 64'h12345678, 0, 1, 64'hFFFFFFFF, 64'h12345678, 1, 0);
    issue(0, 0, 64'h12345678, 0, 1, 64'hFFFFFFFF, 64'h12345678, 1, 0);
    issue(0, 1, 64'h80000000, 64'hFFFFFFFF, 1, 64'h80000000, 0, 0, 0);
    issue(0, 0, 64'h80000000, 64'hFFFFFFFF, 1, 0, 64'h80000000, 0, 32);
    issue(0, 1, 64'hFFFFFF9C, 64'hFFFFFFF9, 1, 14, 64'hFFFFFFFE, 0, 32);
    issue(0, 0, 64'hFFFFFFFF, 1, 1, 64'hFFFFFFFF, 0, 0, 32);
    issue(0, 0, 64'hFFFFFFFF, 64'hFFFFFFFF, 1, 1, 0, 0, 32);
    issue(0, 0, 64'h80000000, 3, 1, 64'h2AAAAAAA, 2, 0, 32);
    drain(0);

    // Backpressure: result must hold, input side must stay closed.
    a_out_ready = 1'b0;
    issue(0, 0, 1000, 10, 1, 100, 0, 0, 32);
    guard = 0;
    while (!a_out_valid && guard < 100) begin @(negedge clk); guard++; end
    chk("A out_valid under backpressure", a_out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("A in_ready in DONE", a_in_ready, 0);
      if (i == 3) begin
        a_in_signed = 1'b0; a_dived = 5; a_divor = 1; a_in_valid = 1'b1;
      end else a_in_valid = 1'b0;
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("A out_valid after release", a_out_valid, 0);
    chk("A in_ready after release", a_in_ready, 1);
    issue(0, 1, 64'hFFFFFFF7, 4, 1, 64'hFFFFFFFE, 64'hFFFFFFFF, 0, 32);
    drain(0);

    issue(1, 1, 8'h80, 8'hFF, 1, 8'h80, 0, 0, 0);
    issue(1, 1, 8'h80, 3, 1, 8'hD6, 8'hFE, 0, 8);
    issue(1, 0, 8'hFF, 0, 1, 8'hFF, 8'hFF, 1, 0);
    drain(1);

    // Reset in the middle of CALC discards the operation in flight.
    issue(0, 0, 100, 7, 0, 0, 0, 0, 0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("A midreset out_valid", a_out_valid, 0);
    chk("A midreset in_ready", a_in_ready, 1);
    chk("A midreset quoti", a_quoti, 0);
    chk("A midreset remai", a_remai, 0);

    issue(1, 1, 8'h80, 8'hFF, 1, 8'h80, 0, 0, 0);
    drain(1);
    issue(1, 0, 200, 13, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("B midreset out_valid", b_out_valid, 0);
    chk("B midreset in_ready", b_in_ready, 1);
    chk("B midreset quoti", b_quoti, 0);
    chk("B midreset remai", b_remai, 0);
    issue(1, 0, 200, 13, 1, 15, 5, 0, 8);
    issue(0, 0, 100, 7, 1, 14, 2, 0, 32);
    drain(1);
    drain(0);

    repeat (40) @(negedge clk);
    chk("A queue empty", qa.size(), 0);
    chk("B queue empty", qb.size(), 0);
    chk("A idle out_valid", a_out_valid, 0);
    chk("B idle out_valid", b_out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time got 2000000 expected completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
